ms_pulse_monitor: RTL and testbench
===================================

# ms_pulse_monitor

Receive-side checker for the millisecond pulse train produced by the pulse generator (`msclock`). It synchronises the incoming pulse and measures the clock-cycle period between consecutive rising edges. It then declares lock after a run of in-tolerance periods, flags loss of pulses by timeout, and counts received milliseconds. It sits next to the generator at top level, or on a board input, and drives status LEDs and the debug readout.

## Interface

Parameters:
- `EXPECT`, default 50000: nominal period in `clk` cycles (1 ms at 50 MHz).
- `TOL`, default 50: allowed absolute deviation from `EXPECT`, inclusive.
- `LOCK_N`, default 4: consecutive in-tolerance periods required for lock; range 1..15.
- `CNT_W`, default 20: width of the period counter. Must satisfy 2*EXPECT < 2^CNT_W.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `pulse_in`, input, 1: incoming ms pulse, asynchronous to `clk`. Pulse width is at least 1 `clk` cycle.
- `clear`, input, 1: synchronous soft clear, level-sensitive.
- `period`, output, CNT_W: last measured period in cycles.
- `period_valid`, output, 1: one-cycle strobe when `period` updates.
- `locked`, output, 1: high while the pulse train is in tolerance.
- `timeout`, output, 1: sticky flag for missing pulses.
- `ms_count`, output, 16: count of detected rising edges; wraps.

## Operation

- Input path:
  - 2-flop synchroniser `s1`, `s2`, then edge register `s3`.
  - `rise = s2 & ~s3`.
- State machine, two states:
  - `WAIT_FIRST` (reset state): `cnt` held at 0. On `rise`, go to `MEASURE` and set `cnt` to 0. No period is reported.
  - `MEASURE`:
    - Each cycle without `rise`, `cnt` increments.
    - On `rise`, `period <= cnt + 1`, `period_valid` pulses, and `cnt` goes back to 0.
    - A steady train of period P cycles therefore reports `period == P`.
- Tolerance check on each measured period:
  - In tolerance when `EXPECT-TOL <= period <= EXPECT+TOL`, using unsigned compare of CNT_W-bit values.
  - In tolerance: the run counter increments, saturating at LOCK_N. `locked` sets when the run counter reaches LOCK_N.
  - Out of tolerance: the run counter goes to 0 and `locked` clears in the same update.
- Timeout:
  - In `MEASURE`, when `cnt == 2*EXPECT-1` and there is no `rise`: set `timeout` (sticky), clear `locked` and the run counter, go to `WAIT_FIRST`.
  - `rise` in the same cycle takes precedence. The period is reported as 2*EXPECT, which is out of tolerance, so lock drops but `timeout` is not set.
- `ms_count` increments on every `rise` in either state and wraps from 0xFFFF to 0.
- `clear`:
  - Forces `WAIT_FIRST` and zeroes `cnt`, `period`, run counter, `locked`, `timeout` and `ms_count`.
  - It wins over a simultaneous `rise`, which is discarded entirely.
  - The synchroniser flops are not cleared.
- Reset (`rst_n` low): every register goes to 0 and the state goes to `WAIT_FIRST`, immediately and asynchronously.
  - This includes the synchroniser and all outputs: `period`=0, `period_valid`=0, `locked`=0, `timeout`=0, `ms_count`=0.
  - Reset mid-measurement discards the partial count.

## Timing

- `pulse_in` rising is seen as `rise` in the cycle after the second `clk` edge that samples it high, so detection latency is 2 cycles.
- `period`, `period_valid`, `locked` and `ms_count` update on the clock edge that ends the `rise` cycle: total latency is 3 edges from input sample.
- `period_valid` is high for exactly one cycle per measured period and never in `WAIT_FIRST`.
- `locked` rises in the same cycle as the `period_valid` of the LOCK_N-th good period. It falls in the same cycle as the `period_valid` of a bad period.
- `timeout` rises one cycle after `cnt` reaches 2*EXPECT-1.
- After `rst_n` deasserts, the first `rise` can occur no earlier than the 3rd clock edge.
- The block accepts any period of 2 cycles or more; shorter periods are undefined.

## Test plan

Use EXPECT=100, TOL=2, LOCK_N=4, CNT_W=8 for the bench.

1. Reset and basic measurement.
   - Stimulus: reset, then a 1-cycle pulse every 100 cycles, 6 pulses.
   - Required: no `period_valid` on pulse 1. Pulses 2..6 each give `period`=100 with a one-cycle `period_valid`. `locked` goes 1 at pulse 5 and stays 1. `ms_count`=6.
2. Tolerance edges.
   - Stimulus: after lock, send periods 102, 98, then 103.
   - Required: `locked` stays 1 through 102 and 98, then drops to 0 at the 103 strobe. Four further periods of 100 are needed to relock.
3. Timeout.
   - Stimulus: after lock, stop pulses.
   - Required: `timeout`=1 and `locked`=0 exactly 200 cycles after the last `rise`. The next pulse produces no `period_valid`. `timeout` stays 1 until `clear`.
4. Simultaneous events.
   - Stimulus A: a pulse placed so that `rise` coincides with `cnt`=199.
   - Required A: `period`=200, `timeout` stays 0, `locked` goes 0.
   - Stimulus B: `clear` asserted in the same cycle as `rise`.
   - Required B: all outputs 0, `ms_count`=0, state `WAIT_FIRST`.
5. Counter wrap.
   - Stimulus: 65537 pulses at period 2.
   - Required: `ms_count` reads 1 after the 65537th pulse, and `period`=2 throughout.
6. Asynchronous reset mid-operation.
   - Stimulus: drop `rst_n` between clock edges partway through a period.
   - Required: all outputs are 0 immediately, without waiting for a clock edge. After release, the first pulse gives no `period_valid` and the second reports the correct period.

Source files
------------

// File: rtl/ms_pulse_monitor_if.sv
// rtl/ms_pulse_monitor_if.sv - pulse input, soft clear and measurement status bundle
interface ms_pulse_monitor_if #(
   parameter int CNT_W = 20
);
   logic             pulse_in;
   logic             clear;
   logic [CNT_W-1:0] period;
   logic             period_valid;
   logic             locked;
   logic             timeout;
   logic [15:0]      ms_count;

   modport master (
      output pulse_in, clear,
      input  period, period_valid, locked, timeout, ms_count
   );

   modport slave (
      input  pulse_in, clear,
      output period, period_valid, locked, timeout, ms_count
   );
endinterface

// File: rtl/ms_pulse_monitor.sv
// rtl/ms_pulse_monitor.sv - ms pulse train period measurement, lock and timeout checker
module ms_pulse_monitor #(
   parameter int EXPECT = 50000,
   parameter int TOL    = 50,
   parameter int LOCK_N = 4,
   parameter int CNT_W  = 20
) (
   input logic                clk,
   input logic                rst_n,
   ms_pulse_monitor_if.slave  mon
);
   typedef enum logic {WAIT_FIRST = 1'b0, MEASURE = 1'b1} state_t;

   localparam logic [CNT_W-1:0] PER_LO   = CNT_W'(EXPECT - TOL);
   localparam logic [CNT_W-1:0] PER_HI   = CNT_W'(EXPECT + TOL);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * EXPECT - 1);
   localparam logic [3:0]       RUN_FULL = 4'(LOCK_N);

   state_t           state_q, state_d;
   logic             s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             period_valid_q, period_valid_d;
   logic [3:0]       run_q, run_d;
   logic             locked_q, locked_d;
   logic             timeout_q, timeout_d;
   logic [15:0]      ms_count_q, ms_count_d;

   logic             rise;
   logic [CNT_W-1:0] period_meas;
   logic             in_tol;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= WAIT_FIRST;
         s1_q           <= 1'b0;
         s2_q           <= 1'b0;
         s3_q           <= 1'b0;
         cnt_q          <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         run_q          <= 4'd0;
         locked_q       <= 1'b0;
         timeout_q      <= 1'b0;
         ms_count_q     <= 16'd0;
      end else begin
         state_q        <= state_d;
         s1_q           <= s1_d;
         s2_q           <= s2_d;
         s3_q           <= s3_d;
         cnt_q          <= cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         run_q          <= run_d;
         locked_q       <= locked_d;
         timeout_q      <= timeout_d;
         ms_count_q     <= ms_count_d;
      end
   end

   always_comb begin
      rise        = s2_q & ~s3_q;
      period_meas = cnt_q + CNT_W'(1);
      in_tol      = (period_meas >= PER_LO) && (period_meas <= PER_HI);

      // The synchroniser keeps running through a soft clear so no edge is fabricated afterwards.
      s1_d           = mon.pulse_in;
      s2_d           = s1_q;
      s3_d           = s2_q;
      state_d        = state_q;
      cnt_d          = cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      run_d          = run_q;
      locked_d       = locked_q;
      timeout_d      = timeout_q;
      ms_count_d     = ms_count_q;

      if (mon.clear) begin
         state_d    = WAIT_FIRST;
         cnt_d      = '0;
         period_d   = '0;
         run_d      = 4'd0;
         locked_d   = 1'b0;
         timeout_d  = 1'b0;
         ms_count_d = 16'd0;
      end else begin
         if (rise) begin
            ms_count_d = ms_count_q + 16'd1;
         end
         unique case (state_q)
            WAIT_FIRST: begin
               cnt_d = '0;
               if (rise) begin
                  state_d = MEASURE;
               end
            end
            MEASURE: begin
               if (rise) begin
                  period_d       = period_meas;
                  period_valid_d = 1'b1;
                  cnt_d          = '0;
                  if (in_tol) begin
                     run_d    = (run_q >= RUN_FULL) ? RUN_FULL : run_q + 4'd1;
                     locked_d = (run_d == RUN_FULL);
                  end else begin
                     run_d    = 4'd0;
                     locked_d = 1'b0;
                  end
               end else if (cnt_q == CNT_LAST) begin
                  // Two nominal periods with no edge: give up and wait for a fresh first pulse.
                  timeout_d = 1'b1;
                  locked_d  = 1'b0;
                  run_d     = 4'd0;
                  cnt_d     = '0;
                  state_d   = WAIT_FIRST;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = WAIT_FIRST;
         endcase
      end
   end

   assign mon.period       = period_q;
   assign mon.period_valid = period_valid_q;
   assign mon.locked       = locked_q;
   assign mon.timeout      = timeout_q;
   assign mon.ms_count     = ms_count_q;
endmodule

// File: tb/tb_ms_pulse_monitor.sv
// tb/tb_ms_pulse_monitor.sv - directed bench for ms_pulse_monitor (EXPECT=100, TOL=2, LOCK_N=4, CNT_W=8)
module tb_ms_pulse_monitor;
   logic clk = 1'b0;
   logic rst_n;

   ms_pulse_monitor_if #(.CNT_W(8)) mif ();

   ms_pulse_monitor #(
      .EXPECT (100),
      .TOL    (2),
      .LOCK_N (4),
      .CNT_W  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mon   (mif)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic       obs_valid, obs_valid_next, obs_locked, obs_timeout;
   logic [7:0] obs_period;
   logic [15:0] obs_ms;

   // One pulse whose rising edge lands gap cycles after the previous one; samples 3 and 4 cycles later.
   task automatic emit(input int gap);
      repeat (gap - 4) @(negedge clk);
      mif.pulse_in = 1'b1;
      @(negedge clk);
      mif.pulse_in = 1'b0;
      repeat (2) @(negedge clk);
      obs_valid   = mif.period_valid;
      obs_period  = mif.period;
      obs_locked  = mif.locked;
      obs_timeout = mif.timeout;
      obs_ms      = mif.ms_count;
      @(negedge clk);
      obs_valid_next = mif.period_valid;
   endtask

   task automatic do_clear();
      @(negedge clk);
      mif.clear = 1'b1;
      @(negedge clk);
      mif.clear = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (mif.period !== 8'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", mif.period); end
      checks++; if (mif.period_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", mif.period_valid); end
      checks++; if (mif.locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", mif.locked); end
      checks++; if (mif.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", mif.timeout); end
      checks++; if (mif.ms_count !== 16'd0) begin errors++; $display("FAIL reset_ms_count: got %0d want 0", mif.ms_count); end
   endtask

   task automatic test_basic();
      emit(4);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL basic_first_valid: got %b want 0", obs_valid); end
      for (int k = 2; k <= 6; k++) begin
         emit(100);
         checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL basic_valid p%0d: got %b want 1", k, obs_valid); end
         checks++; if (obs_valid_next !== 1'b0) begin errors++; $display("FAIL basic_valid_width p%0d: got %b want 0", k, obs_valid_next); end
         checks++; if (obs_period !== 8'd100) begin errors++; $display("FAIL basic_period p%0d: got %0d want 100", k, obs_period); end
         checks++; if (obs_locked !== (k >= 5)) begin errors++; $display("FAIL basic_locked p%0d: got %b want %b", k, obs_locked, (k >= 5)); end
      end
      checks++; if (obs_ms !== 16'd6) begin errors++; $display("FAIL basic_ms_count: got %0d want 6", obs_ms); end
   endtask

   task automatic test_tolerance();
      emit(102);
      checks++; if (obs_period !== 8'd102 || obs_locked !== 1'b1) begin errors++; $display("FAIL tol_102: got period %0d locked %b want 102 1", obs_period, obs_locked); end
      emit(98);
      checks++; if (obs_period !== 8'd98 || obs_locked !== 1'b1) begin errors++; $display("FAIL tol_98: got period %0d locked %b want 98 1", obs_period, obs_locked); end
      emit(103);
      checks++; if (obs_valid !== 1'b1 || obs_period !== 8'd103 || obs_locked !== 1'b0) begin errors++; $display("FAIL tol_103: got valid %b period %0d locked %b want 1 103 0", obs_valid, obs_period, obs_locked); end
      for (int k = 1; k <= 4; k++) begin
         emit(100);
         checks++; if (obs_locked !== (k == 4)) begin errors++; $display("FAIL tol_relock %0d: got %b want %b", k, obs_locked, (k == 4)); end
      end
   endtask

   task automatic test_timeout();
      repeat (198) @(negedge clk);
      checks++; if (mif.timeout !== 1'b0 || mif.locked !== 1'b1) begin errors++; $display("FAIL timeout_early: got timeout %b locked %b want 0 1", mif.timeout, mif.locked); end
      @(negedge clk);
      checks++; if (mif.timeout !== 1'b1 || mif.locked !== 1'b0) begin errors++; $display("FAIL timeout_at_200: got timeout %b locked %b want 1 0", mif.timeout, mif.locked); end
      emit(20);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL timeout_next_valid: got %b want 0", obs_valid); end
      repeat (50) @(negedge clk);
      checks++; if (mif.timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", mif.timeout); end
   endtask

   task automatic test_simultaneous();
      do_clear();
      checks++; if (mif.timeout !== 1'b0 || mif.ms_count !== 16'd0) begin errors++; $display("FAIL clear_state: got timeout %b ms %0d want 0 0", mif.timeout, mif.ms_count); end
      emit(4);
      repeat (4) emit(100);
      checks++; if (obs_locked !== 1'b1) begin errors++; $display("FAIL sim_prelock: got %b want 1", obs_locked); end
      emit(200);
      checks++; if (obs_valid !== 1'b1 || obs_period !== 8'd200) begin errors++; $display("FAIL sim_a_period: got valid %b period %0d want 1 200", obs_valid, obs_period); end
      checks++; if (obs_timeout !== 1'b0 || obs_locked !== 1'b0) begin errors++; $display("FAIL sim_a_flags: got timeout %b locked %b want 0 0", obs_timeout, obs_locked); end
      repeat (10) @(negedge clk);
      mif.pulse_in = 1'b1;
      @(negedge clk);
      mif.pulse_in = 1'b0;
      @(negedge clk);
      mif.clear = 1'b1;
      @(negedge clk);
      mif.clear = 1'b0;
      checks++; if (mif.period !== 8'd0 || mif.period_valid !== 1'b0 || mif.locked !== 1'b0 || mif.timeout !== 1'b0)
         begin errors++; $display("FAIL sim_b_outputs: got period %0d valid %b locked %b timeout %b want all 0", mif.period, mif.period_valid, mif.locked, mif.timeout); end
      checks++; if (mif.ms_count !== 16'd0) begin errors++; $display("FAIL sim_b_ms_count: got %0d want 0", mif.ms_count); end
      emit(50);
      checks++; if (obs_valid !== 1'b0 || obs_ms !== 16'd1) begin errors++; $display("FAIL sim_b_wait_first: got valid %b ms %0d want 0 1", obs_valid, obs_ms); end
   endtask

   task automatic test_wrap();
      int nvalid = 0;
      int nbad   = 0;
      do_clear();
      repeat (4) @(negedge clk);
      for (int i = 0; i < 65537; i++) begin
         mif.pulse_in = 1'b1;
         @(negedge clk);
         if (mif.period_valid) begin nvalid++; if (mif.period !== 8'd2) nbad++; end
         mif.pulse_in = 1'b0;
         @(negedge clk);
         if (mif.period_valid) begin nvalid++; if (mif.period !== 8'd2) nbad++; end
      end
      repeat (3) begin
         @(negedge clk);
         if (mif.period_valid) begin nvalid++; if (mif.period !== 8'd2) nbad++; end
      end
      checks++; if (nbad !== 0) begin errors++; $display("FAIL wrap_period: got %0d periods not 2 want 0", nbad); end
      checks++; if (nvalid !== 65536) begin errors++; $display("FAIL wrap_valid_count: got %0d want 65536", nvalid); end
      checks++; if (mif.ms_count !== 16'd1) begin errors++; $display("FAIL wrap_ms_count: got %0d want 1", mif.ms_count); end
   endtask

   task automatic test_async_reset();
      do_clear();
      emit(4);
      emit(100);
      repeat (40) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (mif.period !== 8'd0 || mif.period_valid !== 1'b0 || mif.locked !== 1'b0 || mif.timeout !== 1'b0 || mif.ms_count !== 16'd0)
         begin errors++; $display("FAIL areset_outputs: got period %0d valid %b locked %b timeout %b ms %0d want all 0", mif.period, mif.period_valid, mif.locked, mif.timeout, mif.ms_count); end
      @(negedge clk);
      rst_n = 1'b1;
      emit(4);
      checks++; if (obs_valid !== 1'b0) begin errors++; $display("FAIL areset_first_valid: got %b want 0", obs_valid); end
      emit(100);
      checks++; if (obs_valid !== 1'b1 || obs_period !== 8'd100) begin errors++; $display("FAIL areset_second: got valid %b period %0d want 1 100", obs_valid, obs_period); end
      checks++; if (obs_ms !== 16'd2) begin errors++; $display("FAIL areset_ms_count: got %0d want 2", obs_ms); end
   endtask

   initial begin
      rst_n        = 1'b0;
      mif.pulse_in = 1'b0;
      mif.clear    = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      test_basic();
      test_tolerance();
      test_timeout();
      test_simultaneous();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
